// File: rtl/count_frame_serializer.sv
// Snapshots the 32-bit counter bytes on a periodic tick and streams them as a
// 6-byte frame (sync, A, B, C, D, XOR checksum) over a valid/ready byte port.
module count_frame_serializer #(
  parameter int unsigned SAMPLE_PERIOD = 1000,
  parameter logic [7:0]  SYNC_BYTE     = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [7:0] a_in,
  input  logic [7:0] b_in,
  input  logic [7:0] c_in,
  input  logic [7:0] d_in,
  output logic       m_valid,
  output logic [7:0] m_data,
  input  logic       m_ready,
  output logic       busy,
  output logic [7:0] overrun_cnt
);

  localparam logic [0:0]  ST_IDLE   = 1'b0;
  localparam logic [0:0]  ST_SEND   = 1'b1;
  localparam logic [23:0] TICK_LAST = 24'(SAMPLE_PERIOD - 1);
  localparam logic [2:0]  IDX_LAST  = 3'd5;

  logic [23:0] tick_cnt_q, tick_cnt_d;
  logic [0:0]  state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  sh_a_q, sh_a_d;
  logic [7:0]  sh_b_q, sh_b_d;
  logic [7:0]  sh_c_q, sh_c_d;
  logic [7:0]  sh_d_q, sh_d_d;
  logic [7:0]  chk_q, chk_d;
  logic [7:0]  ovr_q, ovr_d;

  logic tick;
  logic xfer;
  logic final_xfer;
  logic capture;

  always_comb begin
    tick       = en && (tick_cnt_q == TICK_LAST);
    tick_cnt_d = (!en || tick) ? '0 : tick_cnt_q + 24'd1;
  end

  always_comb begin
    xfer       = m_valid && m_ready;
    final_xfer = xfer && (idx_q == IDX_LAST);
    // A tick landing on the last transfer starts the next frame back-to-back.
    capture    = tick && ((state_q == ST_IDLE) || final_xfer);

    state_d = state_q;
    idx_d   = idx_q;
    sh_a_d  = sh_a_q;
    sh_b_d  = sh_b_q;
    sh_c_d  = sh_c_q;
    sh_d_d  = sh_d_q;
    chk_d   = chk_q;
    ovr_d   = ovr_q;

    case (state_q)
      ST_IDLE: begin
        if (tick) begin
          state_d = ST_SEND;
          idx_d   = '0;
        end
      end
      default: begin
        if (xfer) begin
          if (idx_q == IDX_LAST) begin
            state_d = capture ? ST_SEND : ST_IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
        if (tick && !final_xfer && (ovr_q != '1)) begin
          ovr_d = ovr_q + 8'd1;
        end
      end
    endcase

    if (capture) begin
      sh_a_d = a_in;
      sh_b_d = b_in;
      sh_c_d = c_in;
      sh_d_d = d_in;
      chk_d  = a_in ^ b_in ^ c_in ^ d_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt_q <= '0;
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      sh_a_q     <= '0;
      sh_b_q     <= '0;
      sh_c_q     <= '0;
      sh_d_q     <= '0;
      chk_q      <= '0;
      ovr_q      <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      state_q    <= state_d;
      idx_q      <= idx_d;
      sh_a_q     <= sh_a_d;
      sh_b_q     <= sh_b_d;
      sh_c_q     <= sh_c_d;
      sh_d_q     <= sh_d_d;
      chk_q      <= chk_d;
      ovr_q      <= ovr_d;
    end
  end

  // Byte output is a mux of held registers, so it stays stable while stalled.
  always_comb begin
    m_valid     = (state_q == ST_SEND);
    busy        = (state_q == ST_SEND);
    overrun_cnt = ovr_q;
    m_data      = '0;
    if (state_q == ST_SEND) begin
      case (idx_q)
        3'd0:    m_data = SYNC_BYTE;
        3'd1:    m_data = sh_a_q;
        3'd2:    m_data = sh_b_q;
        3'd3:    m_data = sh_c_q;
        3'd4:    m_data = sh_d_q;
        default: m_data = chk_q;
      endcase
    end
  end

endmodule

// File: tb/tb_count_frame_serializer.sv
// Directed bench for count_frame_serializer: a vector table for the basic
// frame plus hand sequences for stalls, overrun, saturation, reset and enable.
module tb_count_frame_serializer;

  logic       clk = 1'b0;
  logic       rst [4];
  logic       en_s[4];
  logic       rdy [4];
  logic       vld [4];
  logic       bsy [4];
  logic [7:0] dat [4];
  logic [7:0] ovr [4];
  logic [7:0] a, b, c, d;

  int checks = 0;
  int errors = 0;

  logic [7:0] rx[6];
  int         rx_n;

  always #5 clk = ~clk;

  count_frame_serializer #(.SAMPLE_PERIOD(8), .SYNC_BYTE(8'hA5)) u_p8 (
    .clk(clk), .reset(rst[0]), .en(en_s[0]), .a_in(a), .b_in(b), .c_in(c), .d_in(d),
    .m_valid(vld[0]), .m_data(dat[0]), .m_ready(rdy[0]), .busy(bsy[0]), .overrun_cnt(ovr[0]));
  count_frame_serializer #(.SAMPLE_PERIOD(4), .SYNC_BYTE(8'hA5)) u_p4 (
    .clk(clk), .reset(rst[1]), .en(en_s[1]), .a_in(a), .b_in(b), .c_in(c), .d_in(d),
    .m_valid(vld[1]), .m_data(dat[1]), .m_ready(rdy[1]), .busy(bsy[1]), .overrun_cnt(ovr[1]));
  count_frame_serializer #(.SAMPLE_PERIOD(1), .SYNC_BYTE(8'hA5)) u_p1 (
    .clk(clk), .reset(rst[2]), .en(en_s[2]), .a_in(a), .b_in(b), .c_in(c), .d_in(d),
    .m_valid(vld[2]), .m_data(dat[2]), .m_ready(rdy[2]), .busy(bsy[2]), .overrun_cnt(ovr[2]));
  count_frame_serializer #(.SAMPLE_PERIOD(6), .SYNC_BYTE(8'hA5)) u_p6 (
    .clk(clk), .reset(rst[3]), .en(en_s[3]), .a_in(a), .b_in(b), .c_in(c), .d_in(d),
    .m_valid(vld[3]), .m_data(dat[3]), .m_ready(rdy[3]), .busy(bsy[3]), .overrun_cnt(ovr[3]));

  typedef struct {
    logic       en;
    logic       rdy;
    logic [7:0] a, b, c, d;
    logic       ev;
    logic [7:0] ed;
    logic       eb;
    logic [7:0] eo;
  } vec_t;

  vec_t vt[16];

  function automatic vec_t mk(input logic ev, input logic [7:0] ed);
    vec_t v;
    v.en = 1'b1; v.rdy = 1'b1;
    v.a = 8'h11; v.b = 8'h22; v.c = 8'h33; v.d = 8'h44;
    v.ev = ev; v.ed = ed; v.eb = ev; v.eo = 8'h00;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic reset_inst(input int i);
    rst[i] = 1'b1;
    step();
    rst[i] = 1'b0;
  endtask

  task automatic wait_valid(input int i, input int max, output int n);
    n = 0;
    while (n < max && !vld[i]) begin
      step();
      n++;
    end
    if (!vld[i]) n = max + 1;
  endtask

  task automatic collect(input int i, input int max);
    rx_n = 0;
    for (int cy = 0; cy < max && rx_n < 6; cy++) begin
      if (vld[i] && rdy[i]) begin
        rx[rx_n] = dat[i];
        rx_n++;
      end
      step();
    end
  endtask

  initial begin
    int         n;
    int         seen;
    int         got;
    logic       prev_stall;
    logic [7:0] prev_data;
    logic [7:0] exp_b[6];
    logic [7:0] exp_f[6];

    for (int i = 0; i < 4; i++) begin
      rst[i] = 1'b1; en_s[i] = 1'b1; rdy[i] = 1'b1;
    end
    a = 8'h11; b = 8'h22; c = 8'h33; d = 8'h44;
    exp_f[0] = 8'hA5; exp_f[1] = 8'h11; exp_f[2] = 8'h22;
    exp_f[3] = 8'h33; exp_f[4] = 8'h44; exp_f[5] = 8'h44;

    step();
    check("reset_valid", vld[0], 0);
    check("reset_data",  dat[0], 8'h00);
    check("reset_busy",  bsy[0], 0);
    check("reset_ovr",   ovr[0], 8'h00);
    rst[0] = 1'b0;

    // Edges 1..16 after reset release, period 8: frame after edge 8, next after edge 16.
    for (int k = 0; k < 7; k++) vt[k] = mk(1'b0, 8'h00);
    vt[7]  = mk(1'b1, 8'hA5);
    vt[8]  = mk(1'b1, 8'h11);
    vt[9]  = mk(1'b1, 8'h22);
    vt[10] = mk(1'b1, 8'h33);
    vt[11] = mk(1'b1, 8'h44);
    vt[12] = mk(1'b1, 8'h44);
    vt[13] = mk(1'b0, 8'h00);
    vt[14] = mk(1'b0, 8'h00);
    vt[15] = mk(1'b1, 8'hA5);
    for (int k = 0; k < 16; k++) begin
      en_s[0] = vt[k].en; rdy[0] = vt[k].rdy;
      a = vt[k].a; b = vt[k].b; c = vt[k].c; d = vt[k].d;
      step();
      check($sformatf("tbl%0d_valid", k), vld[0], vt[k].ev);
      check($sformatf("tbl%0d_data", k),  dat[0], vt[k].ed);
      check($sformatf("tbl%0d_busy", k),  bsy[0], vt[k].eb);
      check($sformatf("tbl%0d_ovr", k),   ovr[0], vt[k].eo);
    end

    // Backpressure with 1,0,0,1 ready pattern; inputs change after capture.
    a = 8'h01; b = 8'h02; c = 8'h04; d = 8'h08;
    en_s[0] = 1'b1; rdy[0] = 1'b0;
    reset_inst(0);
    wait_valid(0, 20, n);
    check("bp_first_latency", n, 8);
    en_s[0] = 1'b0;
    a = 8'hFF; b = 8'hFF; c = 8'hFF; d = 8'hFF;
    exp_b[0] = 8'hA5; exp_b[1] = 8'h01; exp_b[2] = 8'h02;
    exp_b[3] = 8'h04; exp_b[4] = 8'h08; exp_b[5] = 8'h0F;
    got = 0; prev_stall = 1'b0; prev_data = 8'h00;
    for (int cy = 0; cy < 60 && got < 6; cy++) begin
      rdy[0] = (cy % 4 == 0) || (cy % 4 == 3);
      if (prev_stall) begin
        check("bp_hold_valid", vld[0], 1);
        check("bp_hold_data", dat[0], prev_data);
      end
      if (vld[0] && rdy[0]) begin
        check($sformatf("bp_byte%0d", got), dat[0], exp_b[got]);
        got++;
      end
      prev_stall = vld[0] && !rdy[0];
      prev_data  = dat[0];
      step();
    end
    check("bp_byte_count", got, 6);
    check("bp_idle_after", vld[0], 0);
    seen = 0;
    for (int cy = 0; cy < 20; cy++) begin
      step();
      if (vld[0]) seen++;
    end
    check("en_off_no_frames", seen, 0);
    en_s[0] = 1'b1;
    wait_valid(0, 12, n);
    check("en_resume_latency", n, 8);
    check("en_resume_sync", dat[0], 8'hA5);

    // Enable dropped while idx=2: current frame finishes, nothing follows.
    a = 8'h11; b = 8'h22; c = 8'h33; d = 8'h44;
    en_s[0] = 1'b1; rdy[0] = 1'b1;
    reset_inst(0);
    wait_valid(0, 20, n);
    step();
    step();
    check("endrop_idx2_data", dat[0], 8'h22);
    en_s[0] = 1'b0;
    collect(0, 10);
    check("endrop_rest_count", rx_n, 4);
    for (int j = 0; j < 4; j++) check($sformatf("endrop_byte%0d", j), rx[j], exp_f[j + 2]);
    seen = 0;
    for (int cy = 0; cy < 20; cy++) begin
      if (vld[0]) seen++;
      step();
    end
    check("endrop_no_more", seen, 0);

    // Reset asserted while idx=3.
    en_s[0] = 1'b1; rdy[0] = 1'b1;
    reset_inst(0);
    wait_valid(0, 20, n);
    step(); step(); step();
    check("rstmid_idx3_data", dat[0], 8'h33);
    rst[0] = 1'b1;
    step();
    check("rstmid_valid", vld[0], 0);
    check("rstmid_busy",  bsy[0], 0);
    check("rstmid_data",  dat[0], 8'h00);
    check("rstmid_ovr",   ovr[0], 8'h00);
    rst[0] = 1'b0;
    wait_valid(0, 20, n);
    check("rstmid_restart_latency", n, 8);
    check("rstmid_restart_sync", dat[0], 8'hA5);
    rst[0] = 1'b1;

    // Overrun: period 4, stalled for 40 cycles after first capture.
    a = 8'h10; b = 8'h20; c = 8'h30; d = 8'h40;
    en_s[1] = 1'b1; rdy[1] = 1'b0;
    reset_inst(1);
    wait_valid(1, 10, n);
    check("ovr_first_latency", n, 4);
    for (int cy = 0; cy < 40; cy++) step();
    check("ovr_count_10", ovr[1], 8'd10);
    en_s[1] = 1'b0; rdy[1] = 1'b1;
    collect(1, 20);
    check("ovr_frame_count", rx_n, 6);
    check("ovr_b0", rx[0], 8'hA5);
    check("ovr_b1", rx[1], 8'h10);
    check("ovr_b2", rx[2], 8'h20);
    check("ovr_b3", rx[3], 8'h30);
    check("ovr_b4", rx[4], 8'h40);
    check("ovr_b5", rx[5], 8'h40);
    check("ovr_count_kept", ovr[1], 8'd10);
    rst[1] = 1'b1;

    // Saturation: period 1, stalled 300 cycles.
    en_s[2] = 1'b1; rdy[2] = 1'b0;
    reset_inst(2);
    for (int cy = 0; cy < 300; cy++) step();
    check("sat_255", ovr[2], 8'hFF);
    check("sat_valid_held", vld[2], 1);
    check("sat_data_held", dat[2], 8'hA5);
    for (int cy = 0; cy < 10; cy++) step();
    check("sat_hold", ovr[2], 8'hFF);
    rst[2] = 1'b1;

    // Back-to-back: period 6 equals frame length, m_ready held high.
    a = 8'h11; b = 8'h22; c = 8'h33; d = 8'h44;
    en_s[3] = 1'b1; rdy[3] = 1'b1;
    reset_inst(3);
    wait_valid(3, 12, n);
    check("b2b_first_latency", n, 6);
    for (int j = 0; j < 36; j++) begin
      check($sformatf("b2b_valid%0d", j), vld[3], 1);
      check($sformatf("b2b_data%0d", j), dat[3], exp_f[j % 6]);
      step();
    end
    check("b2b_no_overrun", ovr[3], 8'h00);
    rst[3] = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/count_frame_serializer.md
Name: count_frame_serializer

Overview:
- Downstream consumer of the 32-bit free-running counter, which presents its count as four bytes: a_in (bits 7:0), b_in (15:8), c_in (23:16), d_in (31:24).
- Periodically snapshots the four bytes and packs them into a 6-byte frame: sync byte, four data bytes, XOR checksum.
- Streams the frame one byte at a time over a valid/ready byte interface toward the UART/link transmitter.
- Counts samples dropped because a frame was still in flight.

Parameters:
- SAMPLE_PERIOD, 1000: clock cycles between snapshot ticks while enabled. Legal range 1..2^24-1.
- SYNC_BYTE, 8'hA5: first byte of every frame.

Ports:
- clk  input  1  clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- en  input  1  enables the sample timer
- a_in  input  8  count byte 0 (LSB)
- b_in  input  8  count byte 1
- c_in  input  8  count byte 2
- d_in  input  8  count byte 3 (MSB)
- m_valid  output  1  byte available on m_data
- m_data  output  8  frame byte
- m_ready  input  1  downstream accepts byte
- busy  output  1  frame in progress (state SEND)
- overrun_cnt  output  8  dropped-sample count, saturating

Behaviour:
- Reset: reset is synchronous, active-high; clock is clk. On reset, all of the following are cleared at the next clk edge, regardless of state:
  - m_valid=0, m_data=8'h00, busy=0, overrun_cnt=0
  - timer=0, state IDLE, byte index=0, shadow registers=0
- Timer:
  - While en=1, tick_cnt counts 0..SAMPLE_PERIOD-1 and wraps to 0.
  - tick is asserted for one cycle when tick_cnt==SAMPLE_PERIOD-1 and en=1.
  - While en=0, tick_cnt is held at 0 and no ticks occur.
  - SAMPLE_PERIOD=1 gives a tick every enabled cycle.
- Transfer rule: a byte transfers on a rising edge where m_valid and m_ready are both 1.
- States:
  - IDLE: m_valid=0, busy=0. On tick:
    - latch a_in..d_in into shadow regs and compute chk = a^b^c^d;
    - go to SEND with idx=0.
    - Next cycle: m_valid=1, m_data=SYNC_BYTE.
  - SEND: busy=1. m_data by idx:
    - 0: SYNC_BYTE; 1: A; 2: B; 3: C; 4: D; 5: chk.
    - On transfer with idx<5: idx+1, and the next byte is presented the following cycle.
    - On transfer with idx==5: return to IDLE, m_valid=0 the following cycle.
- Handshake rules:
  - While m_valid=1 and m_ready=0, m_data and m_valid are held stable.
  - m_valid never drops without a transfer, except on reset.
  - m_ready high with m_valid low has no effect.
- Latency and throughput:
  - First byte is valid 1 cycle after the tick.
  - With m_ready held at 1, a frame occupies 6 consecutive cycles.
- Shadow capture: a_in..d_in changes after the capture cycle do not alter the frame in flight.
- Overrun:
  - A tick in SEND, other than in the cycle of the final (idx 5) transfer, is dropped; overrun_cnt increments, saturating at 255.
  - A tick coinciding with the final transfer starts a new frame back-to-back: m_valid stays 1 and m_data=SYNC_BYTE next cycle, with no overrun.
  - overrun_cnt is cleared only by reset.
- en deasserted mid-frame: the current frame completes normally; no new captures occur.
- Widths: chk and all data are 8-bit; no arithmetic beyond XOR, the timer, and the saturating counter.

Test Plan:
- Basic frame: SAMPLE_PERIOD=8, en=1, m_ready=1, inputs 11/22/33/44 -> one cycle after the tick, bytes A5,11,22,33,44,44 on 6 consecutive cycles; busy high for exactly those 6 cycles; next frame starts 8 cycles after the previous tick.
- Backpressure: toggle m_ready 1,0,0,1,... mid-frame -> m_data stable while stalled, no byte lost or duplicated, checksum correct; inputs changed to FF after capture do not appear in the frame.
- Overrun: SAMPLE_PERIOD=4, m_ready=0 for 40 cycles after the first capture, then 1 -> overrun_cnt=10; the first frame is still delivered intact.
- Saturation and back-to-back:
  - SAMPLE_PERIOD=1, m_ready=0 for 300 cycles -> overrun_cnt=255 and holds.
  - SAMPLE_PERIOD=6, m_ready=1 -> continuous frames, m_valid never drops, overrun_cnt=0.
- Reset mid-frame: assert reset during idx=3 -> next edge m_valid=0, busy=0, overrun_cnt=0. After release with en=1, the first tick is SAMPLE_PERIOD cycles later and the frame starts at SYNC_BYTE.
- Enable control: en=0 -> no m_valid ever. Drop en during idx=2 -> frame completes; no further frames until en returns.
